ssd_bcd_scanner: RTL and testbench



---
 rtl/ssd_bcd_scanner.sv | 217 +++++++++++++++++++++
 tb/tb_ssd_bcd_scanner.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ssd_bcd_scanner.sv
// Seven-segment score display: sequential double-dabble binary-to-BCD conversion
// feeding a time-multiplexed common-anode scanner. Optional hex mode: SSD_HEX_MODE_EN.
module ssd_bcd_scanner #(
  parameter int NUM_DIGITS = 2,
  parameter int VALUE_W    = 8,
  parameter int SCAN_DIV   = 18
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [VALUE_W-1:0]    Value,
  input  logic                  Load,
`ifdef SSD_HEX_MODE_EN
  input  logic                  Hex_Mode,
`endif
  output logic                  Busy,
  output logic                  Done,
  output logic                  Overflow,
  output logic [NUM_DIGITS-1:0] An,
  output logic [7:0]            Seg
);

  localparam int DEC_DIGITS = (VALUE_W * 302 + 999) / 1000 + 1;
  // At least one guard nibble above the shown digits so overflow is always detectable.
  localparam int BCD_DIGITS = (DEC_DIGITS > NUM_DIGITS) ? DEC_DIGITS : NUM_DIGITS + 1;
  localparam int BCD_W      = BCD_DIGITS * 4;
  localparam int DISP_W     = NUM_DIGITS * 4;
  localparam int CNT_W      = $clog2(VALUE_W + 1);
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int EXT_W      = ((VALUE_W > DISP_W) ? VALUE_W : DISP_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  state_t                r_state, w_next;
  logic [VALUE_W-1:0]    r_bin;
  logic [BCD_W-1:0]      r_bcd;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_pend;
  logic                  r_pend_hex;
  logic [VALUE_W-1:0]    r_pend_val;
  logic [DISP_W-1:0]     r_disp;
  logic                  r_ovf;
  logic                  r_done;
  logic [SCAN_DIV-1:0]   r_pre;
  logic [IDX_W-1:0]      r_idx;
  logic [NUM_DIGITS-1:0] r_an;
  logic [7:0]            r_seg;

  logic                  w_load_hex;
  logic                  w_capture, w_commit, w_pend_wr, w_pend_clr, w_hex_wr;
  logic [VALUE_W-1:0]    w_cap_val;
  logic [EXT_W-1:0]      w_hex_ext;
  logic [BCD_W-1:0]      w_adj;
  logic [NUM_DIGITS-1:0] w_blank;
  logic                  w_run;
  logic [3:0]            w_nib;
  logic [7:0]            w_seg_next;

`ifdef SSD_HEX_MODE_EN
  assign w_load_hex = Hex_Mode;
`else
  assign w_load_hex = 1'b0;
`endif

  // Valid/ready contract: Load is a single-cycle request with no back-pressure; requests
  // arriving while busy are held in a one-deep pending slot where the newest one wins.
  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_commit   = 1'b0;
    w_pend_wr  = 1'b0;
    w_pend_clr = 1'b0;
    w_hex_wr   = 1'b0;
    w_cap_val  = Load ? Value : r_pend_val;
    case (r_state)
      S_IDLE: begin
        if (Load || r_pend) begin
          w_pend_clr = 1'b1;
          if (Load ? w_load_hex : r_pend_hex) begin
            w_hex_wr = 1'b1;
          end else begin
            w_capture = 1'b1;
            w_next    = S_CONV;
          end
        end
      end
      S_CONV: begin
        w_pend_wr = Load;
        if (r_cnt == CNT_W'(VALUE_W - 1)) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        w_commit  = 1'b1;
        w_pend_wr = Load;
        w_cap_val = r_pend_val;
        // A pending hex request is left for IDLE, which handles it in one cycle.
        if (r_pend && !r_pend_hex) begin
          w_capture  = 1'b1;
          w_pend_clr = 1'b1;
          w_next     = S_CONV;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  assign w_hex_ext = EXT_W'(w_cap_val);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_pend_hex <= 1'b0;
      r_pend_val <= '0;
      r_disp     <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_capture) begin
        r_bin <= w_cap_val;
        r_bcd <= '0;
        r_cnt <= '0;
      end else if (r_state == S_CONV) begin
        r_bcd <= {w_adj[BCD_W-2:0], r_bin[VALUE_W-1]};
        r_bin <= r_bin << 1;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_pend_wr) begin
        r_pend     <= 1'b1;
        r_pend_val <= Value;
        r_pend_hex <= w_load_hex;
      end else if (w_pend_clr) begin
        r_pend <= 1'b0;
      end
      r_done <= w_commit | w_hex_wr;
      if (w_commit) begin
        r_disp <= r_bcd[DISP_W-1:0];
        r_ovf  <= |r_bcd[BCD_W-1:DISP_W];
      end else if (w_hex_wr) begin
        r_disp <= w_hex_ext[DISP_W-1:0];
        r_ovf  <= |(w_hex_ext >> DISP_W);
      end
    end
  end

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 8'b00000010;
      4'h1: glyph = 8'b10011110;
      4'h2: glyph = 8'b00100100;
      4'h3: glyph = 8'b00001100;
      4'h4: glyph = 8'b10011000;
      4'h5: glyph = 8'b01001000;
      4'h6: glyph = 8'b01000000;
      4'h7: glyph = 8'b00011110;
      4'h8: glyph = 8'b00000000;
      4'h9: glyph = 8'b00001000;
`ifdef SSD_HEX_MODE_EN
      4'hA: glyph = 8'b00010000;
      4'hB: glyph = 8'b11000000;
      4'hC: glyph = 8'b01100010;
      4'hD: glyph = 8'b10000100;
      4'hE: glyph = 8'b01100000;
      4'hF: glyph = 8'b01110000;
`endif
      default: glyph = 8'hFF;
    endcase
  endfunction

  // A digit blanks when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    w_blank = '0;
    w_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_run      = w_run & (r_disp[i*4 +: 4] == 4'd0);
      w_blank[i] = w_run && (i != 0);
    end
  end

  assign w_nib      = r_disp[r_idx*4 +: 4];
  assign w_seg_next = r_ovf ? 8'b11111101 : (w_blank[r_idx] ? 8'hFF : glyph(w_nib));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pre <= '0;
      r_idx <= '0;
      r_an  <= '1;
      r_seg <= 8'hFF;
    end else begin
      r_pre <= r_pre + 1'b1;
      if (&r_pre) r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      r_an  <= ~(NUM_DIGITS'(1) << r_idx);
      r_seg <= w_seg_next;
    end
  end

  assign Busy     = (r_state != S_IDLE);
  assign Done     = r_done;
  assign Overflow = r_ovf;
  assign An       = r_an;
  assign Seg      = r_seg;

endmodule

// File: tb/tb_ssd_bcd_scanner.sv
// Directed plus randomized bench for ssd_bcd_scanner; expected digits come from
// decimal arithmetic on the loaded value, not from the conversion algorithm.
module tb_ssd_bcd_scanner;
  localparam int N = 2;
  localparam int W = 8;
  localparam int S = 2;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic [W-1:0] Value;
  logic         Load;
  logic         Busy, Done, Overflow;
  logic [N-1:0] An;
  logic [7:0]   Seg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] glyph_tab [10] = '{8'b00000010, 8'b10011110, 8'b00100100, 8'b00001100,
                                 8'b10011000, 8'b01001000, 8'b01000000, 8'b00011110,
                                 8'b00000000, 8'b00001000};

  ssd_bcd_scanner #(.NUM_DIGITS(N), .VALUE_W(W), .SCAN_DIV(S)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Value(Value), .Load(Load),
`ifdef SSD_HEX_MODE_EN
    .Hex_Mode(1'b0),
`endif
    .Busy(Busy), .Done(Done), .Overflow(Overflow), .An(An), .Seg(Seg)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_seg(input int v, input int i);
    int p;
    p = 10 ** i;
    if (v >= 10 ** N) return 8'b11111101;
    if (i > 0 && v < p) return 8'hFF;
    return glyph_tab[(v / p) % 10];
  endfunction

  task automatic do_load(input int v);
    @(posedge Clk); #1;
    Value = W'(v);
    Load  = 1'b1;
    @(posedge Clk); #1;
    Load  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 64; c++) begin
      @(posedge Clk); #1;
      if (Done) return;
    end
    check($sformatf("%s_done_timeout", tag), 32'd0, 32'd1);
  endtask

  // Observes one full scan round and compares every digit against the model.
  task automatic check_display(input int v, input string tag);
    logic [7:0] obs [N];
    for (int i = 0; i < N; i++) exp_q.push_back(model_seg(v, i));
    for (int c = 0; c < N * (1 << S); c++) begin
      @(posedge Clk); #1;
      check($sformatf("%s_an_onehot", tag), $countones(~An), 1);
      for (int i = 0; i < N; i++) if (An[i] == 1'b0) obs[i] = Seg;
    end
    for (int i = 0; i < N; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check($sformatf("%s_seg%0d", tag, i), obs[i], e);
    end
    check($sformatf("%s_ovf", tag), Overflow, (v >= 10 ** N) ? 1 : 0);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge Clk); #1;
      if (Done) cnt++;
    end
  endtask

  initial begin
    int dcnt;
    int vals [6] = '{0, 9, 10, 99, 100, 255};
    Load = 1'b0; Value = '0; Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_an", An, 2'b11);
    check("rst_seg", Seg, 8'hFF);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_ovf", Overflow, 0);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    check("rel_an", An, 2'b10);
    check("rel_seg", Seg, 8'b00000010);
    check_display(0, "post_reset");

    do_load(7);
    check("v7_busy_e1", Busy, 1);
    check("v7_done_e1", Done, 0);
    for (int e = 2; e <= 12; e++) begin
      @(posedge Clk); #1;
      check($sformatf("v7_busy_e%0d", e), Busy, (e <= 9) ? 1 : 0);
      check($sformatf("v7_done_e%0d", e), Done, (e == 10) ? 1 : 0);
    end
    check_display(7, "v7");

    do_load(42);  wait_done("v42");  check_display(42, "v42");
    do_load(150); wait_done("v150"); check_display(150, "v150");
    do_load(99);  wait_done("v99");  check_display(99, "v99");

    foreach (vals[k]) begin
      do_load(vals[k]); wait_done("edge"); check_display(vals[k], $sformatf("edge%0d", vals[k]));
    end
    repeat (10) begin
      int v;
      v = $urandom_range(0, (1 << W) - 1);
      do_load(v); wait_done("rnd"); check_display(v, $sformatf("rnd%0d", v));
    end

    do_load(99);
    do_load(10);
    do_load(5);
    wait_done("pend_first");
    check("pend_busy_after_first", Busy, 1);
    check_display(99, "pend_99");
    wait_done("pend_second");
    check_display(5, "pend_5");
    count_done(30, dcnt);
    check("pend_no_third_done", dcnt, 0);

    do_load(88);
    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    check("midrst_busy", Busy, 0);
    check("midrst_an", An, 2'b11);
    check("midrst_seg", Seg, 8'hFF);
    check("midrst_done", Done, 0);
    Value = 8'd33; Load = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Load = 1'b0;
    Reset_n = 1'b1;
    count_done(20, dcnt);
    check("midrst_no_done", dcnt, 0);
    check("midrst_busy_after", Busy, 0);
    check_display(0, "midrst_disp");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
